pulse_burst_ctrl: RTL



---
 rtl/pulse_burst_pkg.sv | 15 +
 rtl/pulse_burst_gap_cntr.sv | 29 ++
 rtl/pulse_burst_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pulse_burst_pkg.sv
// rtl/pulse_burst_pkg.sv - shared state encoding and constants for the pulse burst sequencer
package pulse_burst_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_RUN    = 3'd2,
    S_GAP    = 3'd3,
    S_DRAIN  = 3'd4,
    S_FINISH = 3'd5
  } pb_state_t;

  localparam int unsigned GAP_ZERO = 0;

endpackage

// File: rtl/pulse_burst_gap_cntr.sv
// rtl/pulse_burst_gap_cntr.sv - loadable down-counter timing the idle gap between pulses
module pulse_burst_gap_cntr
  import pulse_burst_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !zero) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == WIDTH'(GAP_ZERO));

endmodule

// File: rtl/pulse_burst_ctrl.sv
// rtl/pulse_burst_ctrl.sv - sequences a burst of pulse_gen pulses with a programmable gap
// Optional PULSE_BURST_LOOP_EN adds loop_en: the burst repeats until loop_en drops or abort.
module pulse_burst_ctrl
  import pulse_burst_pkg::*;
#(
  parameter int CNTR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   go,
  input  logic                   abort,
`ifdef PULSE_BURST_LOOP_EN
  input  logic                   loop_en,
`endif
  input  logic [CNTR_WIDTH-1:0]  cfg_period,
  input  logic [CNTR_WIDTH-1:0]  cfg_low,
  input  logic [CNTR_WIDTH-1:0]  cfg_gap,
  input  logic [COUNT_WIDTH-1:0] cfg_count,
  output logic                   pg_start,
  output logic [CNTR_WIDTH-1:0]  pg_cntr_max,
  output logic [CNTR_WIDTH-1:0]  pg_cntr_low,
  input  logic                   pg_start_strobe,
  input  logic                   pg_busy,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic                   cfg_err,
  output logic [COUNT_WIDTH-1:0] pulses_sent
);

  pb_state_t              state;
  logic [CNTR_WIDTH-1:0]  gap_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   loop_wrap;
  logic                   gap_is_zero;
  logic                   last_pulse;
  logic                   run_exit;
  logic                   gap_load;
  logic                   gap_done;

`ifdef PULSE_BURST_LOOP_EN
  assign loop_wrap = loop_en;
`else
  assign loop_wrap = 1'b0;
`endif

  assign gap_is_zero = (gap_q == CNTR_WIDTH'(GAP_ZERO));
  assign last_pulse  = (pulses_sent == count_q);
  assign run_exit    = (state == S_RUN) && !abort && !pg_busy;
  // Loading gap-1 here makes the idle time from pg_busy falling to the next start gap+1 cycles.
  assign gap_load    = run_exit && (!last_pulse || loop_wrap) && !gap_is_zero;

  pulse_burst_gap_cntr #(
    .WIDTH(CNTR_WIDTH)
  ) u_gap_cntr (
    .clk     (clk),
    .nrst    (nrst),
    .load    (gap_load),
    .load_val(gap_q - CNTR_WIDTH'(1)),
    .en      (state == S_GAP),
    .zero    (gap_done)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      pg_start    <= 1'b0;
      pg_cntr_max <= '0;
      pg_cntr_low <= '0;
      gap_q       <= '0;
      count_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
      pulses_sent <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            if (cfg_count == '0 || cfg_period == '0) begin
              cfg_err <= 1'b1;
            end else begin
              pg_cntr_max <= cfg_period;
              pg_cntr_low <= cfg_low;
              gap_q       <= cfg_gap;
              count_q     <= cfg_count;
              pulses_sent <= '0;
              pg_start    <= 1'b1;
              busy        <= 1'b1;
              state       <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          // An accepted start always counts, even when abort arrives in the same cycle.
          if (pg_start_strobe) begin
            pg_start    <= 1'b0;
            pulses_sent <= pulses_sent + COUNT_WIDTH'(1);
            state       <= abort ? S_DRAIN : S_RUN;
          end else if (abort) begin
            pg_start <= 1'b0;
            done     <= 1'b1;
            aborted  <= 1'b1;
            state    <= S_FINISH;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_DRAIN;
          end else if (!pg_busy) begin
            if (last_pulse && !loop_wrap) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              if (last_pulse) begin
                pulses_sent <= '0;
                done        <= 1'b1;
              end
              if (gap_is_zero) begin
                pg_start <= 1'b1;
                state    <= S_LAUNCH;
              end else begin
                state <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (abort) begin
            done    <= 1'b1;
            aborted <= 1'b1;
            state   <= S_FINISH;
          end else if (gap_done) begin
            pg_start <= 1'b1;
            state    <= S_LAUNCH;
          end
        end
        S_DRAIN: begin
          if (!pg_busy) begin
            done    <= 1'b1;
            aborted <= 1'b1;
            state   <= S_FINISH;
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          pg_start <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
